// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and SRAM macro signal bundle for the SRAM port arbiter
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  // requester side, two lanes packed low = M0, high = M1
  logic [1:0]          m_valid;
  logic [1:0]          m_ready;
  logic [1:0]          m_write;
  logic [2*LEN_W-1:0]  m_len;
  logic [2*ADDR_W-1:0] m_addr;
  logic [2*DATA_W-1:0] m_wdata;
  logic [2*STRB_W-1:0] m_wstrb;
  logic [1:0]          m_rvalid;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_last;

  // SRAM macro side
  logic [ADDR_W-1:0]   sram_a;
  logic [DATA_W-1:0]   sram_di;
  logic [DATA_W-1:0]   sram_do;
  logic [STRB_W-1:0]   sram_web;
  logic                sram_cs;
  logic                sram_oe;

  modport slave (
    input  m_valid, m_write, m_len, m_addr, m_wdata, m_wstrb, sram_do,
    output m_ready, m_rvalid, m_rdata, m_last,
    output sram_a, sram_di, sram_web, sram_cs, sram_oe
  );

  modport master (
    output m_valid, m_write, m_len, m_addr, m_wdata, m_wstrb, sram_do,
    input  m_ready, m_rvalid, m_rdata, m_last,
    input  sram_a, sram_di, sram_web, sram_cs, sram_oe
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester round-robin arbiter with burst lock for a single-port SRAM
module sram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_last_q, rr_last_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_id_q, rd_id_d;

  logic [1:0]          req;
  logic                win;
  logic                sel;
  logic                sel_write;
  logic [LEN_W-1:0]    sel_len;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                fire;
  logic                last;

  // Requests are masked while reset is held so nothing is granted or driven to the macro.
  assign req = bus.m_valid & {2{rst}};

  // Tie-break: the requester that did not win last time takes the grant.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~rr_last_q;
    end else begin
      win = req[1];
    end
  end

  // During a burst the owner is the only lane looked at; in IDLE the fresh winner is.
  assign sel       = (state_q == ST_IDLE) ? win : owner_q;
  assign sel_write = sel ? bus.m_write[1] : bus.m_write[0];
  assign sel_len   = sel ? bus.m_len[2*LEN_W-1:LEN_W]    : bus.m_len[LEN_W-1:0];
  assign sel_addr  = sel ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
  assign sel_wdata = sel ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0];
  assign sel_wstrb = sel ? bus.m_wstrb[2*STRB_W-1:STRB_W] : bus.m_wstrb[STRB_W-1:0];

  // Grant/burst FSM next state, handshake outputs and SRAM drive.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    rd_pend_d    = 1'b0;
    rd_id_d      = rd_id_q;
    fire         = 1'b0;
    last         = 1'b0;
    bus.m_ready  = 2'b00;
    bus.m_last   = 2'b00;
    bus.sram_cs  = 1'b0;
    bus.sram_web = '1;
    bus.sram_di  = '0;
    bus.sram_a   = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          fire      = 1'b1;
          owner_d   = win;
          rr_last_d = win;
          len_d     = sel_len;
          if (sel_len == '0) begin
            last = 1'b1;
          end else begin
            state_d    = ST_BURST;
            beat_cnt_d = LEN_W'(1);
          end
        end
      end
      ST_BURST: begin
        // Owner keeps the lock across valid gaps; the other lane stays blocked.
        fire = req[owner_q];
        if (fire) begin
          if (beat_cnt_q == len_q) begin
            last       = 1'b1;
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire || (state_q == ST_BURST && rst)) begin
      bus.m_ready[sel] = 1'b1;
    end
    if (fire && last) begin
      bus.m_last[sel] = 1'b1;
    end

    if (fire) begin
      bus.sram_cs = 1'b1;
      bus.sram_a  = sel_addr;
      addr_d      = sel_addr;
      if (sel_write) begin
        bus.sram_web = ~sel_wstrb;
        bus.sram_di  = sel_wdata;
      end else begin
        rd_pend_d = 1'b1;
        rd_id_d   = sel;
      end
    end
  end

  // Output enable covers the read access cycle and the data return cycle.
  assign bus.sram_oe  = (fire && !sel_write) || rd_pend_q;
  assign bus.m_rvalid = rd_pend_q ? (rd_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_rdata  = bus.sram_do;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      len_q      <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
    end
  end
endmodule
